uart_status_fifo_reg: RTL and testbench

Parametrised next-generation UART status/receive register block, placed between the UART receiver/transmitter and the bus register interface.
- Buffers received characters in a DEPTH-entry first-word-fall-through FIFO instead of a single holding register.
- Keeps sticky error flags (overrun, framing, parity) and live busy/level flags.
- Supports masked read-on-clear.
- Produces a registered, maskable interrupt.

---
 rtl/uart_status_fifo_reg_if.sv | 33 +++
 rtl/uart_status_fifo_reg.sv | 88 ++++++++
 tb/tb_uart_status_fifo_reg.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_status_fifo_reg_if.sv
// Bus bundle between the UART rx/tx front end, the register interface and the
// status/receive FIFO block. master drives events and reads; slave is the block.
interface uart_status_fifo_reg_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1,
  parameter int STAT_W = DATA_W + 8
);
  logic              recv_int;
  logic [DATA_W-1:0] recv_data;
  logic              recv_frame_err;
  logic              recv_parity_err;
  logic              recv_busy;
  logic              tnsm_busy;
  logic              re;
  logic [STAT_W-1:0] rmask;
  logic [3:0]        int_en;
  logic [STAT_W-1:0] status_data;
  logic [CNT_W-1:0]  rx_count;
  logic              irq;

  modport master (
    output recv_int, recv_data, recv_frame_err, recv_parity_err,
    output recv_busy, tnsm_busy, re, rmask, int_en,
    input  status_data, rx_count, irq
  );

  modport slave (
    input  recv_int, recv_data, recv_frame_err, recv_parity_err,
    input  recv_busy, tnsm_busy, re, rmask, int_en,
    output status_data, rx_count, irq
  );
endinterface

// File: rtl/uart_status_fifo_reg.sv
// UART status/receive register block: FWFT receive FIFO, sticky error flags with
// masked read-on-clear, live busy/level flags and a registered maskable interrupt.
module uart_status_fifo_reg #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int THRESH = 2,
  parameter int CNT_W  = $clog2(DEPTH) + 1,
  parameter int STAT_W = DATA_W + 8
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_status_fifo_reg_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int D     = DATA_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_next;
  logic              overrun_q, frame_q, parity_q;
  logic              overrun_next, frame_next, parity_next;
  logic              recv_busy_q, tnsm_busy_q, irq_q;
  logic              empty, full, push, pop, do_write, level_next;
  logic [DATA_W-1:0] head;

  // Mask positions that are neither the pop bit nor a sticky flag are ignored.
  logic unused_rmask;
  assign unused_rmask = ^{bus.rmask[D-1:0], bus.rmask[D+4:D+1]};

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CNT_W'(DEPTH));
    push     = bus.recv_int;
    pop      = bus.re & bus.rmask[D] & ~empty;
    // A push into a full FIFO only lands if the head leaves on the same edge.
    do_write = push & (~full | pop);

    count_next = count_q;
    if (do_write && !pop)      count_next = count_q + CNT_W'(1);
    else if (!do_write && pop) count_next = count_q - CNT_W'(1);

    // Set terms are OR'ed after the clear so a coincident error always wins.
    overrun_next = (overrun_q & ~(bus.re & bus.rmask[D+5])) | (push & full & ~pop);
    frame_next   = (frame_q   & ~(bus.re & bus.rmask[D+6])) | (push & bus.recv_frame_err);
    parity_next  = (parity_q  & ~(bus.re & bus.rmask[D+7])) | (push & bus.recv_parity_err);
    level_next   = (count_next >= CNT_W'(THRESH));
  end

  // NOTE: storage is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr_q] <= bus.recv_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_q     <= 1'b0;
      parity_q    <= 1'b0;
      recv_busy_q <= 1'b0;
      tnsm_busy_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      if (do_write) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)      rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q     <= count_next;
      overrun_q   <= overrun_next;
      frame_q     <= frame_next;
      parity_q    <= parity_next;
      recv_busy_q <= bus.recv_busy;
      tnsm_busy_q <= bus.tnsm_busy;
      irq_q       <= |(bus.int_en & {level_next, overrun_next, frame_next, parity_next});
    end
  end

  assign head            = empty ? '0 : mem[rd_ptr_q];
  assign bus.status_data = {parity_q, frame_q, overrun_q, tnsm_busy_q, recv_busy_q,
                            (count_q >= CNT_W'(THRESH)), full, ~empty, head};
  assign bus.rx_count    = count_q;
  assign bus.irq         = irq_q;

endmodule

// File: tb/tb_uart_status_fifo_reg.sv
// Directed bench for uart_status_fifo_reg (DATA_W=8, DEPTH=4, THRESH=2).
module tb_uart_status_fifo_reg;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int THRESH = 2;
  localparam int CNT_W  = 3;
  localparam int STAT_W = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  uart_status_fifo_reg_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  uart_status_fifo_reg #(.DATA_W(DATA_W), .DEPTH(DEPTH), .THRESH(THRESH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Inputs change 1 ns after a rising edge; outputs are read at that same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.recv_int        = 1'b0;
    bus.recv_data       = '0;
    bus.recv_frame_err  = 1'b0;
    bus.recv_parity_err = 1'b0;
    bus.re              = 1'b0;
    bus.rmask           = '0;
  endtask

  task automatic push(input logic [7:0] d);
    bus.recv_int  = 1'b1;
    bus.recv_data = d;
    step();
    idle();
  endtask

  task automatic pop();
    bus.re    = 1'b1;
    bus.rmask = 16'h0100;
    step();
    idle();
  endtask

  task automatic test_reset();
    idle();
    bus.recv_busy = 1'b0;
    bus.tnsm_busy = 1'b0;
    bus.int_en    = 4'b0000;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (bus.status_data !== 16'h0000) begin errors++; $display("FAIL reset_status: got %h expected 0000", bus.status_data); end
    checks++; if (bus.rx_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.rx_count); end
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", bus.irq); end
  endtask

  task automatic test_single_push();
    push(8'hA5);
    // avail=1, full=0, level=0 -> 0x01A5
    checks++; if (bus.status_data !== 16'h01A5) begin errors++; $display("FAIL single_status: got %h expected 01a5", bus.status_data); end
    checks++; if (bus.rx_count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", bus.rx_count); end
    pop();
    checks++; if (bus.status_data !== 16'h0000) begin errors++; $display("FAIL single_pop_status: got %h expected 0000", bus.status_data); end
  endtask

  task automatic test_overrun();
    logic [7:0] exp_q [4];
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) push(exp_q[i]);
    // avail, full, level set, head 0x11 -> 0x0711
    checks++; if (bus.status_data !== 16'h0711) begin errors++; $display("FAIL full_status: got %h expected 0711", bus.status_data); end
    push(8'h55);
    checks++; if (bus.status_data !== 16'h2711) begin errors++; $display("FAIL overrun_status: got %h expected 2711", bus.status_data); end
    checks++; if (bus.rx_count !== 3'd4) begin errors++; $display("FAIL overrun_count: got %0d expected 4", bus.rx_count); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.status_data[7:0] !== exp_q[i]) begin errors++; $display("FAIL overrun_order%0d: got %h expected %h", i, bus.status_data[7:0], exp_q[i]); end
      pop();
    end
    checks++; if (bus.status_data !== 16'h2000) begin errors++; $display("FAIL drained_status: got %h expected 2000", bus.status_data); end
    bus.re = 1'b1; bus.rmask = 16'h2000; step(); idle();
    checks++; if (bus.status_data !== 16'h0000) begin errors++; $display("FAIL overrun_clear: got %h expected 0000", bus.status_data); end
  endtask

  task automatic test_full_push_pop();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    bus.recv_int = 1'b1; bus.recv_data = 8'h66;
    bus.re = 1'b1; bus.rmask = 16'h0100;
    step(); idle();
    checks++; if (bus.rx_count !== 3'd4) begin errors++; $display("FAIL fullpp_count: got %0d expected 4", bus.rx_count); end
    checks++; if (bus.status_data !== 16'h0722) begin errors++; $display("FAIL fullpp_status: got %h expected 0722", bus.status_data); end
    pop(); pop(); pop();
    checks++; if (bus.status_data !== 16'h0166) begin errors++; $display("FAIL fullpp_tail: got %h expected 0166", bus.status_data); end
    pop();
    checks++; if (bus.rx_count !== 3'd0) begin errors++; $display("FAIL fullpp_drain: got %0d expected 0", bus.rx_count); end
  endtask

  task automatic test_empty_cases();
    pop();
    checks++; if (bus.rx_count !== 3'd0) begin errors++; $display("FAIL empty_pop_count: got %0d expected 0", bus.rx_count); end
    checks++; if (bus.status_data !== 16'h0000) begin errors++; $display("FAIL empty_pop_status: got %h expected 0000", bus.status_data); end
    bus.recv_int = 1'b1; bus.recv_data = 8'h77;
    bus.re = 1'b1; bus.rmask = 16'h0100;
    step(); idle();
    checks++; if (bus.status_data !== 16'h0177) begin errors++; $display("FAIL empty_pushpop: got %h expected 0177", bus.status_data); end
    pop();
  endtask

  task automatic test_errors_irq();
    bus.int_en = 4'b0001;
    bus.recv_int = 1'b1; bus.recv_data = 8'h12; bus.recv_parity_err = 1'b1;
    step(); idle();
    checks++; if (bus.status_data !== 16'h8112) begin errors++; $display("FAIL parity_set: got %h expected 8112", bus.status_data); end
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL parity_irq: got %b expected 1", bus.irq); end
    bus.recv_int = 1'b1; bus.recv_data = 8'h13; bus.recv_parity_err = 1'b1;
    bus.re = 1'b1; bus.rmask = 16'h8000;
    step(); idle();
    checks++; if (bus.status_data !== 16'h8512) begin errors++; $display("FAIL parity_set_wins: got %h expected 8512", bus.status_data); end
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL parity_set_wins_irq: got %b expected 1", bus.irq); end
    bus.re = 1'b1; bus.rmask = 16'h8000; step(); idle();
    checks++; if (bus.status_data !== 16'h0512) begin errors++; $display("FAIL parity_clear: got %h expected 0512", bus.status_data); end
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL parity_clear_irq: got %b expected 0", bus.irq); end
    bus.int_en = 4'b0010;
    bus.recv_int = 1'b1; bus.recv_data = 8'h14; bus.recv_frame_err = 1'b1;
    step(); idle();
    checks++; if (bus.status_data !== 16'h4512) begin errors++; $display("FAIL frame_set: got %h expected 4512", bus.status_data); end
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL frame_irq: got %b expected 1", bus.irq); end
    bus.re = 1'b1; bus.rmask = 16'h1E00; step(); idle();
    checks++; if (bus.rx_count !== 3'd3 || bus.status_data !== 16'h4512) begin errors++; $display("FAIL live_mask_noeffect: got %0d/%h expected 3/4512", bus.rx_count, bus.status_data); end
    bus.int_en = 4'b0000; step();
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL int_en_off: got %b expected 0", bus.irq); end
    bus.re = 1'b1; bus.rmask = 16'h4000; step(); idle();
    pop(); pop();
    checks++; if (bus.status_data !== 16'h0114) begin errors++; $display("FAIL err_last_entry: got %h expected 0114", bus.status_data); end
    pop();
  endtask

  task automatic test_busy();
    bus.recv_busy = 1'b1; bus.tnsm_busy = 1'b0; step();
    checks++; if (bus.status_data !== 16'h0800) begin errors++; $display("FAIL recv_busy: got %h expected 0800", bus.status_data); end
    bus.recv_busy = 1'b0; bus.tnsm_busy = 1'b1; step();
    checks++; if (bus.status_data !== 16'h1000) begin errors++; $display("FAIL tnsm_busy: got %h expected 1000", bus.status_data); end
    bus.tnsm_busy = 1'b0; step();
  endtask

  task automatic test_level_reset();
    bus.int_en = 4'b1000;
    push(8'h01);
    checks++; if (bus.status_data[10] !== 1'b0 || bus.irq !== 1'b0) begin errors++; $display("FAIL level_one: got %b/%b expected 0/0", bus.status_data[10], bus.irq); end
    push(8'h02);
    checks++; if (bus.status_data[10] !== 1'b1 || bus.irq !== 1'b1) begin errors++; $display("FAIL level_two: got %b/%b expected 1/1", bus.status_data[10], bus.irq); end
    pop();
    checks++; if (bus.status_data !== 16'h0102 || bus.irq !== 1'b0) begin errors++; $display("FAIL level_pop: got %h/%b expected 0102/0", bus.status_data, bus.irq); end
    push(8'h03);
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL level_repush: got %b expected 1", bus.irq); end
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if (bus.status_data !== 16'h0000 || bus.rx_count !== 3'd0 || bus.irq !== 1'b0) begin errors++; $display("FAIL midreset: got %h/%0d/%b expected 0000/0/0", bus.status_data, bus.rx_count, bus.irq); end
    bus.int_en = 4'b0000;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 6; i++) begin
      push(8'hA0 + 8'(i));
      checks++; if (bus.status_data !== (16'h0100 | 16'(8'hA0 + 8'(i))) || bus.rx_count !== 3'd1) begin errors++; $display("FAIL wrap_push%0d: got %h/%0d expected head %h count 1", i, bus.status_data, bus.rx_count, 8'hA0 + 8'(i)); end
      pop();
      checks++; if (bus.rx_count !== 3'd0) begin errors++; $display("FAIL wrap_pop%0d: got %0d expected 0", i, bus.rx_count); end
    end
    push(8'hB0);
    for (int i = 1; i < 6; i++) begin
      bus.recv_int = 1'b1; bus.recv_data = 8'hB0 + 8'(i);
      bus.re = 1'b1; bus.rmask = 16'h0100;
      step(); idle();
      checks++; if (bus.status_data !== (16'h0100 | 16'(8'hB0 + 8'(i))) || bus.rx_count !== 3'd1) begin errors++; $display("FAIL wrap_pp%0d: got %h/%0d expected head %h count 1", i, bus.status_data, bus.rx_count, 8'hB0 + 8'(i)); end
    end
    pop();
    checks++; if (bus.rx_count !== 3'd0) begin errors++; $display("FAIL wrap_final: got %0d expected 0", bus.rx_count); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_overrun();
    test_full_push_pop();
    test_empty_cases();
    test_errors_irq();
    test_busy();
    test_level_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
